// File: rtl/rename_rob_ss.sv
// Reorder buffer for a superscalar rename stage: in-order multi-lane dispatch,
// out-of-order completion, in-order multi-lane retire with mispredict squash.
module rename_rob_ss #(
    parameter int unsigned ROB_SZ = 16,
    parameter int unsigned DW     = 2,
    parameter int unsigned CW     = 2,
    parameter int unsigned RW     = 2,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IW     = $clog2(ROB_SZ)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [DW-1:0]       disp_en,
    input  logic [DW*TAG_W-1:0] disp_t,
    input  logic [DW*TAG_W-1:0] disp_t_old,
    input  logic [DW*5-1:0]     disp_dest,
    input  logic [DW*XLEN-1:0]  disp_npc,
    input  logic [DW-1:0]       disp_halt,
    input  logic [DW-1:0]       disp_wr_mem,
    output logic                disp_ready,
    output logic [DW*IW-1:0]    disp_idx,
    input  logic [CW-1:0]       cmp_en,
    input  logic [CW*IW-1:0]    cmp_idx,
    input  logic [CW*XLEN-1:0]  cmp_result,
    input  logic [CW*XLEN-1:0]  cmp_rs2,
    input  logic [CW-1:0]       cmp_take_branch,
    input  logic [CW-1:0]       cmp_mispredict,
    output logic [RW-1:0]       ret_valid,
    output logic [RW*TAG_W-1:0] ret_t,
    output logic [RW*TAG_W-1:0] ret_t_old,
    output logic [RW*5-1:0]     ret_dest,
    output logic [RW*XLEN-1:0]  ret_npc,
    output logic [RW*XLEN-1:0]  ret_result,
    output logic [RW*XLEN-1:0]  ret_rs2,
    output logic [RW-1:0]       ret_halt,
    output logic [RW-1:0]       ret_wr_mem,
    output logic [RW-1:0]       ret_take_branch,
    output logic                flush,
    output logic [IW:0]         count
);

    localparam int unsigned CNT_W = IW + 1;

    typedef struct packed {
        logic             valid;
        logic             complete;
        logic             mispredict;
        logic             take_branch;
        logic             halt;
        logic             wr_mem;
        logic [TAG_W-1:0] t;
        logic [TAG_W-1:0] t_old;
        logic [4:0]       dest;
        logic [XLEN-1:0]  npc;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  rs2;
    } entry_t;

    entry_t           ent_q [ROB_SZ];
    entry_t           ent_d [ROB_SZ];
    logic [IW-1:0]    head_q, head_d;
    logic [IW-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DW-1:0]    disp_acc;
    logic [CNT_W-1:0] n_disp;
    logic [CNT_W-1:0] n_ret;
    logic             disp_pfx;
    logic             ret_ok;
    logic [IW-1:0]    ret_i;
    logic [IW-1:0]    cmp_i;
    logic [IW-1:0]    wr_i;

    // Readiness looks only at the registered occupancy, never at same-cycle retires.
    assign disp_ready = (count_q <= CNT_W'(ROB_SZ - DW));
    assign count      = count_q;

    // Dispatch lanes: only an unbroken prefix of requesting lanes is accepted.
    always_comb begin
        disp_pfx = disp_ready;
        disp_acc = '0;
        disp_idx = '0;
        n_disp   = '0;
        for (int k = 0; k < DW; k++) begin
            disp_idx[k*IW +: IW] = tail_q + IW'(k);
            disp_pfx    = disp_pfx & disp_en[k];
            disp_acc[k] = disp_pfx;
            n_disp      = n_disp + CNT_W'(disp_pfx);
        end
    end

    // Retire group: stops at the first incomplete entry or after a halt/mispredict.
    always_comb begin
        ret_ok          = 1'b1;
        ret_i           = '0;
        ret_valid       = '0;
        flush           = 1'b0;
        n_ret           = '0;
        ret_t           = '0;
        ret_t_old       = '0;
        ret_dest        = '0;
        ret_npc         = '0;
        ret_result      = '0;
        ret_rs2         = '0;
        ret_halt        = '0;
        ret_wr_mem      = '0;
        ret_take_branch = '0;
        for (int k = 0; k < RW; k++) begin
            ret_i = head_q + IW'(k);
            ret_valid[k] = ret_ok && (CNT_W'(k) < count_q) && ent_q[ret_i].complete;
            ret_t[k*TAG_W +: TAG_W]     = ent_q[ret_i].t;
            ret_t_old[k*TAG_W +: TAG_W] = ent_q[ret_i].t_old;
            ret_dest[k*5 +: 5]          = ent_q[ret_i].dest;
            ret_npc[k*XLEN +: XLEN]     = ent_q[ret_i].npc;
            ret_result[k*XLEN +: XLEN]  = ent_q[ret_i].result;
            ret_rs2[k*XLEN +: XLEN]     = ent_q[ret_i].rs2;
            ret_halt[k]                 = ent_q[ret_i].halt;
            ret_wr_mem[k]               = ent_q[ret_i].wr_mem;
            ret_take_branch[k]          = ent_q[ret_i].take_branch;
            flush  = flush | (ret_valid[k] & ent_q[ret_i].mispredict);
            n_ret  = n_ret + CNT_W'(ret_valid[k]);
            ret_ok = ret_valid[k] && !ent_q[ret_i].halt && !ent_q[ret_i].mispredict;
        end
    end

    // Entry updates: completions, then retire invalidation, then squash or dispatch.
    always_comb begin
        ent_d   = ent_q;
        cmp_i   = '0;
        wr_i    = '0;
        head_d  = head_q + IW'(n_ret);
        tail_d  = tail_q;
        count_d = count_q;

        for (int j = 0; j < CW; j++) begin
            cmp_i = cmp_idx[j*IW +: IW];
            if (cmp_en[j] && ent_q[cmp_i].valid) begin
                ent_d[cmp_i].complete    = 1'b1;
                ent_d[cmp_i].result      = cmp_result[j*XLEN +: XLEN];
                ent_d[cmp_i].rs2         = cmp_rs2[j*XLEN +: XLEN];
                ent_d[cmp_i].take_branch = cmp_take_branch[j];
                ent_d[cmp_i].mispredict  = cmp_mispredict[j];
            end
        end

        for (int k = 0; k < RW; k++) begin
            if (ret_valid[k]) begin
                ent_d[head_q + IW'(k)].valid    = 1'b0;
                ent_d[head_q + IW'(k)].complete = 1'b0;
            end
        end

        if (flush) begin
            for (int i = 0; i < ROB_SZ; i++) begin
                ent_d[i].valid    = 1'b0;
                ent_d[i].complete = 1'b0;
            end
            tail_d  = head_d;
            count_d = '0;
        end else begin
            for (int k = 0; k < DW; k++) begin
                if (disp_acc[k]) begin
                    wr_i = tail_q + IW'(k);
                    ent_d[wr_i].valid       = 1'b1;
                    ent_d[wr_i].complete    = 1'b0;
                    ent_d[wr_i].mispredict  = 1'b0;
                    ent_d[wr_i].take_branch = 1'b0;
                    ent_d[wr_i].halt        = disp_halt[k];
                    ent_d[wr_i].wr_mem      = disp_wr_mem[k];
                    ent_d[wr_i].t           = disp_t[k*TAG_W +: TAG_W];
                    ent_d[wr_i].t_old       = disp_t_old[k*TAG_W +: TAG_W];
                    ent_d[wr_i].dest        = disp_dest[k*5 +: 5];
                    ent_d[wr_i].npc         = disp_npc[k*XLEN +: XLEN];
                    ent_d[wr_i].result      = '0;
                    ent_d[wr_i].rs2         = '0;
                end
            end
            tail_d  = tail_q + IW'(n_disp);
            count_d = count_q + n_disp - n_ret;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_SZ; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ent_q   <= ent_d;
        end
    end

endmodule

// File: tb/tb_rename_rob_ss.sv
// Directed vector bench for rename_rob_ss with ROB_SZ=8 and two lanes per port group.
module tb_rename_rob_ss;

    localparam int unsigned ROB_SZ = 8;
    localparam int unsigned DW     = 2;
    localparam int unsigned CW     = 2;
    localparam int unsigned RW     = 2;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned IW     = 3;
    localparam int          NV     = 34;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [DW-1:0]       disp_en;
    logic [DW*TAG_W-1:0] disp_t;
    logic [DW*TAG_W-1:0] disp_t_old;
    logic [DW*5-1:0]     disp_dest;
    logic [DW*XLEN-1:0]  disp_npc;
    logic [DW-1:0]       disp_halt;
    logic [DW-1:0]       disp_wr_mem;
    logic                disp_ready;
    logic [DW*IW-1:0]    disp_idx;
    logic [CW-1:0]       cmp_en;
    logic [CW*IW-1:0]    cmp_idx;
    logic [CW*XLEN-1:0]  cmp_result;
    logic [CW*XLEN-1:0]  cmp_rs2;
    logic [CW-1:0]       cmp_take_branch;
    logic [CW-1:0]       cmp_mispredict;
    logic [RW-1:0]       ret_valid;
    logic [RW*TAG_W-1:0] ret_t;
    logic [RW*TAG_W-1:0] ret_t_old;
    logic [RW*5-1:0]     ret_dest;
    logic [RW*XLEN-1:0]  ret_npc;
    logic [RW*XLEN-1:0]  ret_result;
    logic [RW*XLEN-1:0]  ret_rs2;
    logic [RW-1:0]       ret_halt;
    logic [RW-1:0]       ret_wr_mem;
    logic [RW-1:0]       ret_take_branch;
    logic                flush;
    logic [IW:0]         count;

    rename_rob_ss #(
        .ROB_SZ(ROB_SZ), .DW(DW), .CW(CW), .RW(RW), .TAG_W(TAG_W), .XLEN(XLEN), .IW(IW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .disp_en(disp_en), .disp_t(disp_t), .disp_t_old(disp_t_old),
        .disp_dest(disp_dest), .disp_npc(disp_npc), .disp_halt(disp_halt),
        .disp_wr_mem(disp_wr_mem), .disp_ready(disp_ready), .disp_idx(disp_idx),
        .cmp_en(cmp_en), .cmp_idx(cmp_idx), .cmp_result(cmp_result), .cmp_rs2(cmp_rs2),
        .cmp_take_branch(cmp_take_branch), .cmp_mispredict(cmp_mispredict),
        .ret_valid(ret_valid), .ret_t(ret_t), .ret_t_old(ret_t_old), .ret_dest(ret_dest),
        .ret_npc(ret_npc), .ret_result(ret_result), .ret_rs2(ret_rs2),
        .ret_halt(ret_halt), .ret_wr_mem(ret_wr_mem), .ret_take_branch(ret_take_branch),
        .flush(flush), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  den;
        logic [1:0]  dhalt;
        logic [1:0]  cen;
        logic [2:0]  ci0;
        logic [2:0]  ci1;
        logic [31:0] cr0;
        logic [31:0] cr1;
        logic [1:0]  mp;
        logic [3:0]  e_cnt;
        logic        e_rdy;
        logic [1:0]  e_rv;
        logic        e_fl;
        logic [5:0]  e_idx;
        logic        chk_res;
        logic [31:0] e_res;
    } vec_t;

    vec_t vecs [NV];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        input logic [1:0] den, input logic [1:0] dhalt, input logic [1:0] cen,
        input logic [2:0] ci0, input logic [2:0] ci1, input logic [31:0] cr0,
        input logic [31:0] cr1, input logic [1:0] mp, input logic [3:0] e_cnt,
        input logic e_rdy, input logic [1:0] e_rv, input logic e_fl,
        input logic [5:0] e_idx, input logic chk_res, input logic [31:0] e_res);
        vec_t v;
        v.den = den; v.dhalt = dhalt; v.cen = cen; v.ci0 = ci0; v.ci1 = ci1;
        v.cr0 = cr0; v.cr1 = cr1; v.mp = mp; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
        v.e_rv = e_rv; v.e_fl = e_fl; v.e_idx = e_idx; v.chk_res = chk_res; v.e_res = e_res;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'd0);
        chk({tag, ".disp_ready"}, 32'(disp_ready), 32'd1);
        chk({tag, ".ret_valid"}, 32'(ret_valid), 32'd0);
        chk({tag, ".flush"}, 32'(flush), 32'd0);
        chk({tag, ".disp_idx"}, 32'(disp_idx), 32'o10);
    endtask

    task automatic apply(input int n, input vec_t v);
        @(negedge clock);
        disp_en        = v.den;
        disp_halt      = v.dhalt;
        cmp_en         = v.cen;
        cmp_idx        = {v.ci1, v.ci0};
        cmp_result     = {v.cr1, v.cr0};
        cmp_mispredict = v.mp;
        disp_t         = {6'(2 * n + 1), 6'(2 * n)};
        disp_npc       = {32'(n + 100), 32'(n)};
        #1;
        chk($sformatf("v%0d.count", n), 32'(count), 32'(v.e_cnt));
        chk($sformatf("v%0d.disp_ready", n), 32'(disp_ready), 32'(v.e_rdy));
        chk($sformatf("v%0d.ret_valid", n), 32'(ret_valid), 32'(v.e_rv));
        chk($sformatf("v%0d.flush", n), 32'(flush), 32'(v.e_fl));
        chk($sformatf("v%0d.disp_idx", n), 32'(disp_idx), 32'(v.e_idx));
        if (v.chk_res) chk($sformatf("v%0d.ret_result0", n), ret_result[31:0], v.e_res);
    endtask

    initial begin
        //          den   dh    cen   ci0 ci1 cr0    cr1 mp    cnt rdy rv    fl idx    chk res
        // Fill to full, then complete out of order and retire two at once.
        vecs[0]  = mk(2'b11, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 0, 1, 2'b00, 0, 6'o10, 0, 0);
        vecs[1]  = mk(2'b11, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 2, 1, 2'b00, 0, 6'o32, 0, 0);
        vecs[2]  = mk(2'b11, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 4, 1, 2'b00, 0, 6'o54, 0, 0);
        vecs[3]  = mk(2'b11, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 6, 1, 2'b00, 0, 6'o76, 0, 0);
        vecs[4]  = mk(2'b11, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 8, 0, 2'b00, 0, 6'o10, 0, 0);
        vecs[5]  = mk(2'b00, 2'b00, 2'b01, 1, 0, 0,     0, 2'b00, 8, 0, 2'b00, 0, 6'o10, 0, 0);
        vecs[6]  = mk(2'b00, 2'b00, 2'b01, 0, 0, 'hA0,  0, 2'b00, 8, 0, 2'b00, 0, 6'o10, 0, 0);
        vecs[7]  = mk(2'b00, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 8, 0, 2'b11, 0, 6'o10, 1, 'hA0);
        // Same-index double completion: port 1 must win.
        vecs[8]  = mk(2'b01, 2'b00, 2'b11, 2, 2, 5,     9, 2'b00, 6, 1, 2'b00, 0, 6'o10, 0, 0);
        vecs[9]  = mk(2'b00, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 7, 0, 2'b01, 0, 6'o21, 1, 9);
        vecs[10] = mk(2'b00, 2'b00, 2'b01, 3, 0, 0,     0, 2'b00, 6, 1, 2'b00, 0, 6'o21, 0, 0);
        vecs[11] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 6, 1, 2'b01, 0, 6'o21, 0, 0);
        vecs[12] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 5, 1, 2'b00, 0, 6'o21, 0, 0);
        // After reset: completion to an empty slot is ignored, then mispredict flush.
        vecs[13] = mk(2'b00, 2'b00, 2'b01, 0, 0, 0,     0, 2'b00, 0, 1, 2'b00, 0, 6'o10, 0, 0);
        vecs[14] = mk(2'b01, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 0, 1, 2'b00, 0, 6'o10, 0, 0);
        vecs[15] = mk(2'b11, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 1, 1, 2'b00, 0, 6'o21, 0, 0);
        vecs[16] = mk(2'b01, 2'b00, 2'b11, 1, 2, 0,     0, 2'b00, 3, 1, 2'b00, 0, 6'o43, 0, 0);
        vecs[17] = mk(2'b00, 2'b00, 2'b11, 3, 0, 0,     0, 2'b10, 4, 1, 2'b00, 0, 6'o54, 0, 0);
        vecs[18] = mk(2'b11, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 4, 1, 2'b01, 1, 6'o54, 0, 0);
        vecs[19] = mk(2'b11, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 0, 1, 2'b00, 0, 6'o21, 0, 0);
        vecs[20] = mk(2'b00, 2'b00, 2'b11, 1, 2, 0,     0, 2'b00, 2, 1, 2'b00, 0, 6'o43, 0, 0);
        vecs[21] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 2, 1, 2'b11, 0, 6'o43, 0, 0);
        // Walk head to 7, then a dispatch/retire group that wraps 7 -> 0.
        vecs[22] = mk(2'b11, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 0, 1, 2'b00, 0, 6'o43, 0, 0);
        vecs[23] = mk(2'b11, 2'b00, 2'b11, 3, 4, 0,     0, 2'b00, 2, 1, 2'b00, 0, 6'o65, 0, 0);
        vecs[24] = mk(2'b00, 2'b00, 2'b11, 5, 6, 0,     0, 2'b00, 4, 1, 2'b11, 0, 6'o07, 0, 0);
        vecs[25] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 2, 1, 2'b11, 0, 6'o07, 0, 0);
        vecs[26] = mk(2'b11, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 0, 1, 2'b00, 0, 6'o07, 0, 0);
        vecs[27] = mk(2'b00, 2'b00, 2'b11, 7, 0, 0,     0, 2'b00, 2, 1, 2'b00, 0, 6'o21, 0, 0);
        vecs[28] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 2, 1, 2'b11, 0, 6'o21, 0, 0);
        // Halt on the older lane splits the retire group.
        vecs[29] = mk(2'b11, 2'b01, 2'b00, 0, 0, 0,     0, 2'b00, 0, 1, 2'b00, 0, 6'o21, 0, 0);
        vecs[30] = mk(2'b00, 2'b00, 2'b11, 1, 2, 0,     0, 2'b00, 2, 1, 2'b00, 0, 6'o43, 0, 0);
        vecs[31] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 2, 1, 2'b01, 0, 6'o43, 0, 0);
        vecs[32] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 1, 1, 2'b01, 0, 6'o43, 0, 0);
        vecs[33] = mk(2'b00, 2'b00, 2'b00, 0, 0, 0,     0, 2'b00, 0, 1, 2'b00, 0, 6'o43, 0, 0);

        reset_n         = 1'b0;
        disp_en         = '0;
        disp_t          = '0;
        disp_t_old      = '0;
        disp_dest       = '0;
        disp_npc        = '0;
        disp_halt       = '0;
        disp_wr_mem     = '0;
        cmp_en          = '0;
        cmp_idx         = '0;
        cmp_result      = '0;
        cmp_rs2         = '0;
        cmp_take_branch = '0;
        cmp_mispredict  = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset_state("por");
        reset_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i == 13) begin
                // Asynchronous reset mid-operation with five live entries and tail at 1.
                @(negedge clock);
                disp_en = '0;
                cmp_en  = '0;
                #2;
                reset_n = 1'b0;
                #1;
                chk_reset_state("async_rst");
                disp_en = 2'b11;
                @(posedge clock);
                #1;
                chk_reset_state("rst_held");
                disp_en = '0;
                @(negedge clock);
                reset_n = 1'b1;
            end
            apply(i, vecs[i]);
        end

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
